led_pattern_seq: RTL and testbench
==================================

# led_pattern_seq

Downstream consumer of the 10 Hz clock-enable tick produced by the decade divider on the 1 MHz divided clock. Drives the four board LEDs with one of four selectable patterns, advanced one step per tick. A raw push button, debounced in tick units, cycles through the patterns. Replaces the plain 4-bit binary counter as the LED driver in `top`.

## Interface
- `DEB_TICKS`, default 3: consecutive CE ticks a new button level must persist before acceptance (300 ms at 10 Hz); legal range 1..7.
- `C`  in  1  clock, the 1 MHz divided clock; all state on the rising edge.
- `CLR_N`  in  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low.
- `CE`  in  1  one-cycle step tick from the divider; may be high on any cycle.
- `BTN`  in  1  raw push button, active-high, asynchronous to `C`, bouncing.
- `LEDS`  out  4  registered LED pattern.
- `MODE`  out  2  registered current mode.

## Operation
- Reset values: `LEDS`=4'b0000, `MODE`=2'd0, synchronizer FFs=0, debounced level=0, debounce count=0, bounce direction=up.
- `BTN` passes through a 2-FF synchronizer, clocked every `C` cycle regardless of `CE`.
- Debounce, evaluated only on cycles with `CE`=1:
  - synced level != debounced level: count+1; when count reaches `DEB_TICKS`, debounced level takes the synced level and count clears.
  - synced level == debounced level: count clears.
  - `CE`=0: count and level hold.
- Press event: one-cycle pulse when the debounced level goes 0->1. Release generates no event.
- On a press event, at the next `C` edge: `MODE` <= `MODE`+1, wrapping 3->0; `LEDS` loads the new mode's initial pattern; direction resets to up.
- Modes. Pattern advances only on `CE`=1.
  - 0 COUNT: init 0000; binary +1, 1111->0000.
  - 1 WALK: init 0001; rotate left, 1000->0001.
  - 2 BOUNCE: init 0001; 0001,0010,0100,1000,0100,0010,0001,0010,...; direction flips at 1000 and at 0001, and end values are shown once per sweep.
  - 3 BLINK: init 0000; toggles 0000<->1111.
- Press event and `CE` on the same cycle: mode change wins. `LEDS` loads the new initial pattern, and that tick does not advance the pattern. The debounce logic still consumes the tick.
- `CLR_N` asserted mid-operation: all state returns to reset values immediately. No partial step or pending press survives deassertion.

## Timing
- `LEDS` changes on the `C` edge where `CE`=1; visible in the following cycle. Pattern latency is 1 cycle from tick.
- Press latency: 2 cycles of synchronization. The debounced level then rises at the `DEB_TICKS`-th consecutive qualifying `CE` edge. `MODE` and `LEDS` update one `C` edge later.
- One press yields exactly one mode step, however long it is held.
- Glitches shorter than `DEB_TICKS` ticks produce no event.

## Structure
- Shared package/include `led_seq_pkg`:
  - mode encodings `MODE_COUNT`=0, `MODE_WALK`=1, `MODE_BOUNCE`=2, `MODE_BLINK`=3;
  - initial patterns per mode;
  - `DIR_UP`/`DIR_DOWN`.
- Sub-module `btn_debounce` holds the synchronizer, debounce counter and rising-edge pulse. Ports: `C`, `CLR_N`, `CE`, `BTN_IN`, `LEVEL`, `PRESS`.
- Top of block: mode register and pattern state machine.

## Test plan
- Reset, then 20 `CE` ticks with `BTN`=0 -> `MODE`=0; `LEDS` runs 0001..1111, 0000, 0001..0100 (tick 16 wraps to 0000); never changes on non-`CE` cycles.
- `BTN` held high through 3 ticks (`DEB_TICKS`=3) -> exactly one press. `MODE`=1 and `LEDS`=0001 one cycle after the debounced rise. Next tick gives 0010.
- `BTN` pulsing high for 2 ticks, low for 1, repeated 10 times -> no mode change.
- Mode 2 for 8 ticks from 0001 -> sequence 0010,0100,1000,0100,0010,0001,0010,0100.
- Press event coincident with `CE` while in mode 3 -> `MODE`=0, `LEDS`=0000, no extra advance. Four presses total from reset return to `MODE`=0.
- `CLR_N` pulsed low mid-bounce in mode 2 with debounce count at 2 -> `LEDS`=0000, `MODE`=0 asynchronously. After release, the next press needs a full 3 ticks.

Source files
------------

// File: rtl/led_pattern_seq_pkg.sv
// Shared encodings for the LED pattern sequencer: mode codes, bounce
// direction and the pattern each mode starts from.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_WALK   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [3:0] INIT_COUNT  = 4'b0000;
    localparam logic [3:0] INIT_WALK   = 4'b0001;
    localparam logic [3:0] INIT_BOUNCE = 4'b0001;
    localparam logic [3:0] INIT_BLINK  = 4'b0000;

    function automatic logic [3:0] init_pattern(input mode_e m);
        logic [3:0] p;
        case (m)
            MODE_COUNT:  p = INIT_COUNT;
            MODE_WALK:   p = INIT_WALK;
            MODE_BOUNCE: p = INIT_BOUNCE;
            default:     p = INIT_BLINK;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/led_pattern_seq_if.sv
// Step tick / button inputs and LED / mode outputs of the LED sequencer.
interface led_pattern_seq_if;
    logic       CE;
    logic       BTN;
    logic [3:0] LEDS;
    logic [1:0] MODE;

    modport master (output CE, output BTN, input LEDS, input MODE);
    modport slave  (input CE, input BTN, output LEDS, output MODE);
endinterface

// File: rtl/led_pattern_seq_btn_debounce.sv
// Button conditioning: 2-FF synchronizer, tick-based debounce counter and
// a one-cycle pulse on each accepted rising level.
module btn_debounce #(
    parameter int DEB_TICKS = 3
) (
    input  logic C,
    input  logic CLR_N,
    input  logic CE,
    input  logic BTN_IN,
    output logic LEVEL,
    output logic PRESS
);

    localparam logic [2:0] DEB_CNT = 3'(DEB_TICKS);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       level_q, level_d;
    logic       level_prev_q, level_prev_d;
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d      = BTN_IN;
        sync2_d      = sync1_q;
        level_prev_d = level_q;
        level_d      = level_q;
        cnt_d        = cnt_q;
        if (CE) begin
            if (sync2_q != level_q) begin
                // A level is accepted only after DEB_TICKS consecutive disagreeing ticks.
                if (cnt_q + 3'd1 == DEB_CNT) begin
                    level_d = sync2_q;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end else begin
                cnt_d = 3'd0;
            end
        end
    end

    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= 3'd0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            cnt_q        <= cnt_d;
        end
    end

    assign LEVEL = level_q;
    assign PRESS = level_q & ~level_prev_q;

endmodule

// File: rtl/led_pattern_seq.sv
// Four-LED pattern driver: a debounced button cycles the mode, each CE tick
// advances the current mode's pattern by one step.
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int DEB_TICKS = 3
) (
    input  logic               C,
    input  logic               CLR_N,
    led_pattern_seq_if.slave   bus
);

    mode_e      mode_q, mode_d;
    dir_e       dir_q, dir_d;
    logic [3:0] leds_q, leds_d;
    logic       press;
    logic       level;

    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_debounce (
        .C      (C),
        .CLR_N  (CLR_N),
        .CE     (bus.CE),
        .BTN_IN (bus.BTN),
        .LEVEL  (level),
        .PRESS  (press)
    );

    always_comb begin
        mode_d = mode_q;
        dir_d  = dir_q;
        leds_d = leds_q;
        // A press overrides a coincident tick: the new mode starts from its initial pattern.
        if (press) begin
            mode_d = mode_e'(mode_q + 2'd1);
            leds_d = init_pattern(mode_d);
            dir_d  = DIR_UP;
        end else if (bus.CE) begin
            case (mode_q)
                MODE_COUNT: leds_d = leds_q + 4'd1;
                MODE_WALK:  leds_d = {leds_q[2:0], leds_q[3]};
                MODE_BOUNCE: begin
                    // Turn around at either end so each end lamp is lit once per sweep.
                    if (dir_q == DIR_UP) begin
                        if (leds_q[3]) begin
                            dir_d  = DIR_DOWN;
                            leds_d = leds_q >> 1;
                        end else begin
                            leds_d = leds_q << 1;
                        end
                    end else begin
                        if (leds_q[0]) begin
                            dir_d  = DIR_UP;
                            leds_d = leds_q << 1;
                        end else begin
                            leds_d = leds_q >> 1;
                        end
                    end
                end
                default:    leds_d = ~leds_q;
            endcase
        end
    end

    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            mode_q <= MODE_COUNT;
            dir_q  <= DIR_UP;
            leds_q <= 4'b0000;
        end else begin
            mode_q <= mode_d;
            dir_q  <= dir_d;
            leds_q <= leds_d;
        end
    end

    assign bus.LEDS = leds_q;
    assign bus.MODE = mode_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq against a step-index reference model.
module tb_led_pattern_seq;

    localparam int DEB = 3;

    logic C;
    logic CLR_N;
    int   n_checks = 0;
    int   n_errors = 0;

    led_pattern_seq_if bus ();

    led_pattern_seq #(.DEB_TICKS(DEB)) dut (
        .C     (C),
        .CLR_N (CLR_N),
        .bus   (bus)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    // Reference model: button history, debounce bookkeeping, mode and the
    // number of steps taken since the mode was entered.
    logic       m_s1, m_s2, m_level, m_prev;
    int         m_cnt, m_k, m_presses;
    logic [1:0] m_mode;

    function automatic logic [3:0] exp_leds(input logic [1:0] mode, input int k);
        int pos;
        case (k % 6)
            0: pos = 0;
            1: pos = 1;
            2: pos = 2;
            3: pos = 3;
            4: pos = 2;
            default: pos = 1;
        endcase
        case (mode)
            2'd0:    return 4'(k % 16);
            2'd1:    return 4'(1 << (k % 4));
            2'd2:    return 4'(1 << pos);
            default: return (k % 2) ? 4'hF : 4'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_level = 0; m_prev = 0;
        m_cnt = 0; m_k = 0; m_mode = 2'd0;
    endtask

    task automatic model_edge(input logic ce, input logic btn);
        logic press;
        logic synced;
        press  = m_level & ~m_prev;
        synced = m_s2;
        m_prev = m_level;
        if (ce) begin
            if (synced != m_level) begin
                m_cnt++;
                if (m_cnt == DEB) begin
                    m_level = synced;
                    m_cnt   = 0;
                end
            end else begin
                m_cnt = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = btn;
        if (press) begin
            m_mode = m_mode + 2'd1;
            m_k    = 0;
            m_presses++;
        end else if (ce) begin
            m_k++;
        end
    endtask

    task automatic step(input logic ce, input logic btn);
        @(negedge C);
        bus.CE  = ce;
        bus.BTN = btn;
        @(posedge C);
        model_edge(ce, btn);
        #1;
    endtask

    // One CE tick, spaced so the synchronizer has settled on btn before it.
    task automatic tick(input logic btn);
        for (int i = 0; i < 3; i++) step(1'b0, btn);
        step(1'b1, btn);
    endtask

    // Hold the button until the model reports a pending press, then take the
    // press on a non-CE cycle.
    task automatic do_press();
        int guard;
        guard = 0;
        while (!(m_level && !m_prev) && guard < 20) begin
            tick(1'b1);
            guard++;
        end
        n_checks++;
        if (guard >= 20) begin
            n_errors++;
            $display("FAIL press_timeout: got no press after %0d ticks, required press within %0d", guard, DEB + 2);
        end
        step(1'b0, 1'b1);
        n_checks++;
        if ({bus.MODE, bus.LEDS} !== {m_mode, exp_leds(m_mode, m_k)}) begin
            n_errors++;
            $display("FAIL press_step: got mode=%0d leds=%b, required mode=%0d leds=%b",
                     bus.MODE, bus.LEDS, m_mode, exp_leds(m_mode, m_k));
        end
    endtask

    task automatic test_reset();
        CLR_N   = 1'b0;
        bus.CE  = 1'b0;
        bus.BTN = 1'b0;
        model_reset();
        m_presses = 0;
        #12;
        n_checks++;
        if ({bus.MODE, bus.LEDS} !== 6'b00_0000) begin
            n_errors++;
            $display("FAIL reset_state: got mode=%0d leds=%b, required mode=0 leds=0000", bus.MODE, bus.LEDS);
        end
        @(negedge C);
        CLR_N = 1'b1;
    endtask

    task automatic test_count();
        for (int t = 1; t <= 20; t++) begin
            int idle;
            idle = $urandom_range(0, 3);
            for (int i = 0; i < idle; i++) begin
                step(1'b0, 1'b0);
                n_checks++;
                if ({bus.MODE, bus.LEDS} !== {m_mode, exp_leds(m_mode, m_k)}) begin
                    n_errors++;
                    $display("FAIL count_idle%0d: got mode=%0d leds=%b, required mode=%0d leds=%b",
                             t, bus.MODE, bus.LEDS, m_mode, exp_leds(m_mode, m_k));
                end
            end
            step(1'b1, 1'b0);
            n_checks++;
            if ({bus.MODE, bus.LEDS} !== {2'd0, 4'(t % 16)}) begin
                n_errors++;
                $display("FAIL count_tick%0d: got mode=%0d leds=%b, required mode=0 leds=%b",
                         t, bus.MODE, bus.LEDS, 4'(t % 16));
            end
        end
    endtask

    task automatic test_press_hold();
        do_press();
        n_checks++;
        if ({bus.MODE, bus.LEDS} !== {2'd1, 4'b0001}) begin
            n_errors++;
            $display("FAIL press_to_walk: got mode=%0d leds=%b, required mode=1 leds=0001", bus.MODE, bus.LEDS);
        end
        tick(1'b1);
        n_checks++;
        if (bus.LEDS !== 4'b0010) begin
            n_errors++;
            $display("FAIL walk_first_tick: got leds=%b, required leds=0010", bus.LEDS);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b1);
            n_checks++;
            if ({bus.MODE, bus.LEDS} !== {2'd1, exp_leds(m_mode, m_k)}) begin
                n_errors++;
                $display("FAIL hold_tick%0d: got mode=%0d leds=%b, required mode=1 leds=%b",
                         i, bus.MODE, bus.LEDS, exp_leds(m_mode, m_k));
            end
        end
        for (int i = 0; i < 4; i++) tick(1'b0);
    endtask

    task automatic test_glitch();
        for (int r = 0; r < 10; r++) begin
            tick(1'b1);
            tick(1'b1);
            tick(1'b0);
            n_checks++;
            if ({bus.MODE, bus.LEDS} !== {2'd1, exp_leds(m_mode, m_k)}) begin
                n_errors++;
                $display("FAIL glitch_round%0d: got mode=%0d leds=%b, required mode=1 leds=%b",
                         r, bus.MODE, bus.LEDS, exp_leds(m_mode, m_k));
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] seq [8];
        seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
        do_press();
        n_checks++;
        if ({bus.MODE, bus.LEDS} !== {2'd2, 4'b0001}) begin
            n_errors++;
            $display("FAIL press_to_bounce: got mode=%0d leds=%b, required mode=2 leds=0001", bus.MODE, bus.LEDS);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0);
            n_checks++;
            if ({bus.MODE, bus.LEDS} !== {2'd2, seq[i]}) begin
                n_errors++;
                $display("FAIL bounce_tick%0d: got mode=%0d leds=%b, required mode=2 leds=%b",
                         i, bus.MODE, bus.LEDS, seq[i]);
            end
        end
    endtask

    task automatic test_coincident();
        int guard;
        do_press();
        for (int i = 0; i < 4; i++) tick(1'b0);
        n_checks++;
        if (bus.MODE !== 2'd3) begin
            n_errors++;
            $display("FAIL press_to_blink: got mode=%0d, required mode=3", bus.MODE);
        end
        guard = 0;
        while (!(m_level && !m_prev) && guard < 20) begin
            tick(1'b1);
            guard++;
        end
        // CE arrives on the very cycle the press pulse is high.
        step(1'b1, 1'b1);
        n_checks++;
        if ({bus.MODE, bus.LEDS} !== {2'd0, 4'b0000}) begin
            n_errors++;
            $display("FAIL coincident_press: got mode=%0d leds=%b, required mode=0 leds=0000", bus.MODE, bus.LEDS);
        end
        n_checks++;
        if (m_presses != 4) begin
            n_errors++;
            $display("FAIL press_count: got %0d presses, required 4", m_presses);
        end
        tick(1'b1);
        n_checks++;
        if ({bus.MODE, bus.LEDS} !== {2'd0, 4'b0001}) begin
            n_errors++;
            $display("FAIL after_coincident: got mode=%0d leds=%b, required mode=0 leds=0001", bus.MODE, bus.LEDS);
        end
        for (int i = 0; i < 4; i++) tick(1'b0);
    endtask

    task automatic test_clear_mid();
        do_press();
        for (int i = 0; i < 4; i++) tick(1'b0);
        do_press();
        for (int i = 0; i < 5; i++) tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        #2;
        CLR_N = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({bus.MODE, bus.LEDS} !== 6'b00_0000) begin
            n_errors++;
            $display("FAIL async_clear: got mode=%0d leds=%b, required mode=0 leds=0000", bus.MODE, bus.LEDS);
        end
        @(negedge C);
        CLR_N = 1'b1;
        tick(1'b1);
        tick(1'b1);
        step(1'b0, 1'b1);
        n_checks++;
        if (bus.MODE !== 2'd0) begin
            n_errors++;
            $display("FAIL clear_two_ticks: got mode=%0d, required mode=0", bus.MODE);
        end
        tick(1'b1);
        step(1'b0, 1'b1);
        n_checks++;
        if ({bus.MODE, bus.LEDS} !== {2'd1, 4'b0001}) begin
            n_errors++;
            $display("FAIL clear_third_tick: got mode=%0d leds=%b, required mode=1 leds=0001", bus.MODE, bus.LEDS);
        end
    endtask

    task automatic test_random();
        logic btn;
        int   hold;
        btn  = 1'b0;
        hold = 0;
        for (int c = 0; c < 600; c++) begin
            if (hold == 0) begin
                btn  = ~btn;
                hold = $urandom_range(1, 40);
            end
            hold--;
            step(($urandom_range(0, 3) == 0), btn);
            n_checks++;
            if ({bus.MODE, bus.LEDS} !== {m_mode, exp_leds(m_mode, m_k)}) begin
                n_errors++;
                $display("FAIL random_cycle%0d: got mode=%0d leds=%b, required mode=%0d leds=%b",
                         c, bus.MODE, bus.LEDS, m_mode, exp_leds(m_mode, m_k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_press_hold();
        test_glitch();
        test_bounce();
        test_coincident();
        test_clear_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
